// File: rtl/picorv32_pcpi_arbiter_pkg.sv
// Shared types and constants for the PicoRV32 PCPI RV32M arbiter.
package picorv32_pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    SEL_MUL = 1'b0,
    SEL_DIV = 1'b1
  } slave_sel_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/picorv32_pcpi_arbiter_if.sv
// PCPI request/response bundle; master drives the request, slave returns the result.
interface picorv32_pcpi_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/picorv32_pcpi_decode.sv
// Combinational RV32M claim/select decode for the PCPI arbiter.
module picorv32_pcpi_decode
  import picorv32_pcpi_pkg::*;
#(
  parameter int ENABLE_DIV = 1
) (
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  output logic        claim,
  output slave_sel_t  sel
);

  localparam logic DIV_EN = (ENABLE_DIV != 32'sd0);

  logic unused_insn_s;
  assign unused_insn_s = &{1'b0, pcpi_insn[24:15], pcpi_insn[13:7]};

  // Claim only RV32M encodings; the divide group only when a div slave exists.
  always_comb begin
    claim = 1'b0;
    sel   = SEL_MUL;
    if (pcpi_valid && (pcpi_insn[6:0] == OPCODE_OP) &&
        (pcpi_insn[31:25] == FUNCT7_MULDIV) && (!pcpi_insn[14] || DIV_EN)) begin
      claim = 1'b1;
    end else begin
      claim = 1'b0;
    end
    if (pcpi_insn[14]) begin
      sel = SEL_DIV;
    end else begin
      sel = SEL_MUL;
    end
  end

endmodule

// File: rtl/picorv32_pcpi_arbiter.sv
// Routes core PCPI requests to a mul or div co-processor with registered issue/response.
// Define PCPI_ARB_TIMEOUT_EN to abort a slave that stays silent for TIMEOUT_CYCLES.
module picorv32_pcpi_arbiter
  import picorv32_pcpi_pkg::*;
#(
  parameter int ENABLE_DIV     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  picorv32_pcpi_if.slave  core,
  picorv32_pcpi_if.master mul,
  picorv32_pcpi_if.master div,
  output logic            timeout_pulse
);

  arb_state_t  state_r;
  slave_sel_t  sel_r;
  slave_sel_t  sel_s;
  logic        claim_s;
  logic [31:0] insn_r, rs1_r, rs2_r;
  logic        mul_valid_r, div_valid_r;
  logic        wait_r, ready_r, wr_r;
  logic [31:0] rd_r;
  logic        sel_ready_s, sel_wr_s;
  logic [31:0] sel_rd_s;

  picorv32_pcpi_decode #(
    .ENABLE_DIV (ENABLE_DIV)
  ) u_decode (
    .pcpi_valid (core.pcpi_valid),
    .pcpi_insn  (core.pcpi_insn),
    .claim      (claim_s),
    .sel        (sel_s)
  );

  // Response of the slave that owns the in-flight request; the other one is ignored.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_wr_s    = 1'b0;
    sel_rd_s    = 32'h0000_0000;
    case (sel_r)
      SEL_MUL: begin
        sel_ready_s = mul.pcpi_ready;
        sel_wr_s    = mul.pcpi_wr;
        sel_rd_s    = mul.pcpi_rd;
      end
      SEL_DIV: begin
        sel_ready_s = div.pcpi_ready;
        sel_wr_s    = div.pcpi_wr;
        sel_rd_s    = div.pcpi_rd;
      end
      default: begin
        sel_ready_s = 1'b0;
        sel_wr_s    = 1'b0;
        sel_rd_s    = 32'h0000_0000;
      end
    endcase
  end

`ifdef PCPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Arbiter FSM; every output is a register so slaves never see a combinational valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= SEL_MUL;
      insn_r      <= 32'h0000_0000;
      rs1_r       <= 32'h0000_0000;
      rs2_r       <= 32'h0000_0000;
      mul_valid_r <= 1'b0;
      div_valid_r <= 1'b0;
      wait_r      <= 1'b0;
      ready_r     <= 1'b0;
      wr_r        <= 1'b0;
      rd_r        <= 32'h0000_0000;
`ifdef PCPI_ARB_TIMEOUT_EN
      cnt_r       <= {CNT_W{1'b0}};
      timeout_r   <= 1'b0;
`endif
    end else begin
      ready_r <= 1'b0;
`ifdef PCPI_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (claim_s) begin
            insn_r      <= core.pcpi_insn;
            rs1_r       <= core.pcpi_rs1;
            rs2_r       <= core.pcpi_rs2;
            sel_r       <= sel_s;
            mul_valid_r <= (sel_s == SEL_MUL);
            div_valid_r <= (sel_s == SEL_DIV);
            wait_r      <= 1'b1;
            state_r     <= ST_ISSUE;
`ifdef PCPI_ARB_TIMEOUT_EN
            cnt_r       <= {CNT_W{1'b0}};
`endif
          end
        end
        ST_ISSUE: begin
          if (sel_ready_s) begin
            wr_r        <= sel_wr_s;
            rd_r        <= sel_rd_s;
            ready_r     <= 1'b1;
            wait_r      <= 1'b0;
            mul_valid_r <= 1'b0;
            div_valid_r <= 1'b0;
            state_r     <= ST_RESP;
`ifdef PCPI_ARB_TIMEOUT_EN
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort without a ready so the core's own PCPI timeout traps the insn.
            wait_r      <= 1'b0;
            mul_valid_r <= 1'b0;
            div_valid_r <= 1'b0;
            timeout_r   <= 1'b1;
            state_r     <= ST_DRAIN;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
`endif
          end
        end
        ST_RESP: begin
          wr_r    <= 1'b0;
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!core.pcpi_valid) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          wait_r      <= 1'b0;
          mul_valid_r <= 1'b0;
          div_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PCPI_ARB_TIMEOUT_EN
  assign timeout_pulse = timeout_r;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign core.pcpi_wait  = wait_r;
  assign core.pcpi_ready = ready_r;
  assign core.pcpi_wr    = wr_r;
  assign core.pcpi_rd    = rd_r;

  assign mul.pcpi_valid = mul_valid_r;
  assign mul.pcpi_insn  = insn_r;
  assign mul.pcpi_rs1   = rs1_r;
  assign mul.pcpi_rs2   = rs2_r;
  assign div.pcpi_valid = div_valid_r;
  assign div.pcpi_insn  = insn_r;
  assign div.pcpi_rs1   = rs1_r;
  assign div.pcpi_rs2   = rs2_r;

  logic unused_wait_s;
  assign unused_wait_s = &{1'b0, mul.pcpi_wait, div.pcpi_wait};

endmodule

// File: tb/tb_picorv32_pcpi_arbiter.sv
// Scoreboard bench for picorv32_pcpi_arbiter with behavioural mul/div slaves.
module tb_picorv32_pcpi_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  picorv32_pcpi_if core_if ();
  picorv32_pcpi_if mul_if ();
  picorv32_pcpi_if div_if ();
  picorv32_pcpi_if core2_if ();
  picorv32_pcpi_if mul2_if ();
  picorv32_pcpi_if div2_if ();
  logic timeout_pulse, timeout2;

  picorv32_pcpi_arbiter dut (
    .clk (clk), .reset (reset), .core (core_if), .mul (mul_if), .div (div_if),
    .timeout_pulse (timeout_pulse)
  );

  picorv32_pcpi_arbiter #(.ENABLE_DIV (0), .TIMEOUT_CYCLES (8)) dut2 (
    .clk (clk), .reset (reset), .core (core2_if), .mul (mul2_if), .div (div2_if),
    .timeout_pulse (timeout2)
  );

  // Behavioural slaves: ready appears LAT cycles after valid first becomes visible.
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 10;
  int unsigned mul_cnt = 0, div_cnt = 0;
  logic        mul_rdy_r = 1'b0, div_rdy_r = 1'b0;
  logic [31:0] mul_rd_r = 32'h0;
  logic        mul_inj = 1'b0, mul2_inj = 1'b0;

  assign mul_if.pcpi_ready  = mul_rdy_r | mul_inj;
  assign mul_if.pcpi_wr     = mul_rdy_r | mul_inj;
  assign mul_if.pcpi_rd     = mul_rd_r;
  assign mul_if.pcpi_wait   = mul_if.pcpi_valid;
  assign div_if.pcpi_ready  = div_rdy_r;
  assign div_if.pcpi_wr     = div_rdy_r;
  assign div_if.pcpi_rd     = 32'h0000_0003;
  assign div_if.pcpi_wait   = div_if.pcpi_valid;
  assign mul2_if.pcpi_ready = mul2_inj;
  assign mul2_if.pcpi_wr    = mul2_inj;
  assign mul2_if.pcpi_rd    = 32'hDEAD_BEEF;
  assign mul2_if.pcpi_wait  = 1'b0;
  assign div2_if.pcpi_ready = 1'b0;
  assign div2_if.pcpi_wr    = 1'b0;
  assign div2_if.pcpi_rd    = 32'h0;
  assign div2_if.pcpi_wait  = 1'b0;

  function automatic logic [31:0] mul_calc(input logic [31:0] insn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (insn[13:12] == 2'b01 || insn[13:12] == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (insn[13:12] == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (insn[13:12] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk) begin
    if (mul_rdy_r) begin
      mul_rdy_r <= 1'b0;
      mul_cnt   <= 0;
    end else if (mul_if.pcpi_valid) begin
      if (mul_cnt == MUL_LAT - 1) begin
        mul_rdy_r <= 1'b1;
        mul_rd_r  <= mul_calc(mul_if.pcpi_insn, mul_if.pcpi_rs1, mul_if.pcpi_rs2);
      end
      mul_cnt <= mul_cnt + 1;
    end else begin
      mul_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (div_rdy_r) begin
      div_rdy_r <= 1'b0;
      div_cnt   <= 0;
    end else if (div_if.pcpi_valid) begin
      if (div_cnt == DIV_LAT - 1) div_rdy_r <= 1'b1;
      div_cnt <= div_cnt + 1;
    end else begin
      div_cnt <= 0;
    end
  end

  // Scoreboard: expected responses queued by stimulus, popped on each core ready.
  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (!reset && core_if.pcpi_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got ready rd=%h, expected no response", core_if.pcpi_rd);
      end else begin
        sb_e = exp_q.pop_front();
        if (core_if.pcpi_wr !== sb_e.wr || core_if.pcpi_rd !== sb_e.rd) begin
          n_fail++;
          $display("FAIL sb_resp: got wr=%b rd=%h, expected wr=%b rd=%h",
                   core_if.pcpi_wr, core_if.pcpi_rd, sb_e.wr, sb_e.rd);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Main DUT request; masks record each signal per cycle after the claim edge (bit i = T+i).
  task automatic run_req(input string name, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input bit expect_resp,
                         input logic [31:0] exp_rd, input logic [31:0] e_wait,
                         input logic [31:0] e_mulv, input logic [31:0] e_divv,
                         input logic [31:0] e_rdy);
    logic [31:0] m_wait, m_mulv, m_divv, m_rdy, m_tmo;
    bit held;
    m_wait = 32'h0; m_mulv = 32'h0; m_divv = 32'h0; m_rdy = 32'h0; m_tmo = 32'h0;
    @(negedge clk);
    if (expect_resp) exp_q.push_back('{wr: 1'b1, rd: exp_rd});
    core_if.pcpi_insn  = insn;
    core_if.pcpi_rs1   = rs1;
    core_if.pcpi_rs2   = rs2;
    core_if.pcpi_valid = 1'b1;
    held = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      m_wait[i] = core_if.pcpi_wait;
      m_mulv[i] = mul_if.pcpi_valid;
      m_divv[i] = div_if.pcpi_valid;
      m_rdy[i]  = core_if.pcpi_ready;
      m_tmo[i]  = timeout_pulse;
      if (i == 1 && (e_mulv | e_divv) != 32'h0)
        chk({name, "_insn_copy"}, insn[14] ? div_if.pcpi_insn : mul_if.pcpi_insn, insn);
      if (held && (core_if.pcpi_ready || (!expect_resp && i == 4))) begin
        core_if.pcpi_valid = 1'b0;
        held = 1'b0;
      end
    end
    core_if.pcpi_valid = 1'b0;
    chk({name, "_wait"}, m_wait, e_wait);
    chk({name, "_mul_valid"}, m_mulv, e_mulv);
    chk({name, "_div_valid"}, m_divv, e_divv);
    chk({name, "_ready"}, m_rdy, e_rdy);
    chk({name, "_timeout"}, m_tmo, 32'h0);
  endtask

  // Second DUT (ENABLE_DIV=0, TIMEOUT_CYCLES=8); its mul slave is silent unless injected.
  task automatic run_req2(input string name, input logic [31:0] insn, input int drop_at,
                          input int inj_at, input logic [31:0] e_wait,
                          input logic [31:0] e_mulv, input logic [31:0] e_tmo);
    logic [31:0] m_wait, m_mulv, m_divv, m_rdy, m_tmo;
    m_wait = 32'h0; m_mulv = 32'h0; m_divv = 32'h0; m_rdy = 32'h0; m_tmo = 32'h0;
    @(negedge clk);
    core2_if.pcpi_insn  = insn;
    core2_if.pcpi_rs1   = 32'h5;
    core2_if.pcpi_rs2   = 32'h6;
    core2_if.pcpi_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      m_wait[i] = core2_if.pcpi_wait;
      m_mulv[i] = mul2_if.pcpi_valid;
      m_divv[i] = div2_if.pcpi_valid;
      m_rdy[i]  = core2_if.pcpi_ready;
      m_tmo[i]  = timeout2;
      mul2_inj = (i == inj_at);
      if (i == drop_at) core2_if.pcpi_valid = 1'b0;
    end
    mul2_inj = 1'b0;
    core2_if.pcpi_valid = 1'b0;
    chk({name, "_wait"}, m_wait, e_wait);
    chk({name, "_mul_valid"}, m_mulv, e_mulv);
    chk({name, "_div_valid"}, m_divv, 32'h0);
    chk({name, "_ready"}, m_rdy, 32'h0);
    chk({name, "_timeout"}, m_tmo, e_tmo);
  endtask

  initial begin
    logic [31:0] idle_rdy;
    int rdy_cnt, rdy_at;
    core_if.pcpi_valid = 1'b0; core_if.pcpi_insn = 32'h0;
    core_if.pcpi_rs1 = 32'h0;  core_if.pcpi_rs2 = 32'h0;
    core2_if.pcpi_valid = 1'b0; core2_if.pcpi_insn = 32'h0;
    core2_if.pcpi_rs1 = 32'h0;  core2_if.pcpi_rs2 = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {27'h0, core_if.pcpi_wait, core_if.pcpi_ready, core_if.pcpi_wr,
                      mul_if.pcpi_valid, div_if.pcpi_valid}, 32'h0);
    chk("reset_rd", core_if.pcpi_rd, 32'h0);
    chk("reset_operands", mul_if.pcpi_insn | mul_if.pcpi_rs1 | mul_if.pcpi_rs2, 32'h0);
    reset = 1'b0;

    run_req("mul", mk(7'b0000001, 3'b000), 32'd7, 32'd6, 1'b1, 32'd42,
            32'h0000_000E, 32'h0000_000E, 32'h0, 32'h0000_0010);
    run_req("mulhu", mk(7'b0000001, 3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
            32'hFFFF_FFFE, 32'h0000_000E, 32'h0000_000E, 32'h0, 32'h0000_0010);
    run_req("mulh", mk(7'b0000001, 3'b001), 32'hFFFF_FFFE, 32'd3, 1'b1,
            32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_000E, 32'h0, 32'h0000_0010);
    run_req("div", mk(7'b0000001, 3'b100), 32'd10, 32'd3, 1'b1, 32'h0000_0003,
            32'h0000_0FFE, 32'h0, 32'h0000_0FFE, 32'h0000_1000);
    run_req("add", mk(7'b0000000, 3'b000), 32'd1, 32'd2, 1'b0, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0);

    // A stray slave ready while idle must not reach the core.
    idle_rdy = 32'h0;
    @(negedge clk); mul_inj = 1'b1;
    @(negedge clk); mul_inj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_rdy[i] = core_if.pcpi_ready;
    end
    chk("idle_stray_ready", idle_rdy, 32'h0);

    run_req2("nodiv_divu", mk(7'b0000001, 3'b101), 4, 0, 32'h0, 32'h0, 32'h0);
    run_req2("nodiv_add", mk(7'b0000000, 3'b000), 4, 0, 32'h0, 32'h0, 32'h0);
`ifdef PCPI_ARB_TIMEOUT_EN
    run_req2("timeout", mk(7'b0000001, 3'b000), 14, 11, 32'h0000_01FE, 32'h0000_01FE,
             32'h0000_0200);
`else
    run_req2("hang", mk(7'b0000001, 3'b000), 4, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0);
`endif

    // Async reset during ISSUE drops the request; a still-held valid is claimed afresh.
    @(negedge clk);
    exp_q.push_back('{wr: 1'b1, rd: 32'h0000_0003});
    core_if.pcpi_insn  = mk(7'b0000001, 3'b100);
    core_if.pcpi_rs1   = 32'd9;
    core_if.pcpi_rs2   = 32'd3;
    core_if.pcpi_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pre_issue", {31'h0, div_if.pcpi_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ctl", {27'h0, core_if.pcpi_wait, core_if.pcpi_ready, div_if.pcpi_valid,
                          timeout_pulse, core_if.pcpi_wr}, 32'h0);
    chk("rst_async_data", div_if.pcpi_insn | div_if.pcpi_rs1 | core_if.pcpi_rd, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('{wr: 1'b1, rd: 32'h0000_0003});
    rdy_cnt = 0;
    rdy_at  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (core_if.pcpi_ready) begin
        rdy_cnt++;
        if (rdy_at == 0) rdy_at = i;
        core_if.pcpi_valid = 1'b0;
      end
    end
    core_if.pcpi_valid = 1'b0;
    chk("rst_reclaim_count", rdy_cnt, 32'd1);
    chk("rst_reclaim_cycle", rdy_at, 32'd12);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
